// File: rtl/router_input_port_if.sv
// Handshake bundle between one input FIFO, the output arbiter and a router input port.
// The master side is the input port itself; the slave side is the FIFO/arbiter/crossbar.
interface router_input_port_if #(
    parameter int FLIT_W = 4
);
    logic              fifo_empty;
    logic [FLIT_W-1:0] fifo_flit;
    logic              read_fifo;
    logic [4:0]        dest_full_vector;
    logic              grant;
    logic [4:0]        request_vector;
    logic [2:0]        destination_port;
    logic [FLIT_W-1:0] flit_out;
    logic              flit_valid;
    logic              packet_done;
    logic              busy;

    modport master (
        input  fifo_empty, fifo_flit, dest_full_vector, grant,
        output read_fifo, request_vector, destination_port, flit_out, flit_valid,
               packet_done, busy
    );

    modport slave (
        output fifo_empty, fifo_flit, dest_full_vector, grant,
        input  read_fifo, request_vector, destination_port, flit_out, flit_valid,
               packet_done, busy
    );
endinterface

// File: rtl/router_input_port.sv
// Mesh router input port: assembles a relative-offset header from the FIFO, routes XY,
// then forwards the decremented header and a fixed-length payload under grant/backpressure.
module router_input_port #(
    parameter int FLIT_W        = 4,
    parameter int ADDR_W        = 16,
    parameter int PAYLOAD_FLITS = 4
) (
    input logic                 clk,
    input logic                 reset,
    router_input_port_if.master port
);
    localparam int H      = ADDR_W / FLIT_W;
    localparam int HALF   = ADDR_W / 2;
    localparam int HCNT_W = $clog2(H + 1);
    localparam int PCNT_W = $clog2(PAYLOAD_FLITS + 1);
    localparam logic [HCNT_W-1:0] HDR_LAST = HCNT_W'(H - 1);
    localparam logic [PCNT_W-1:0] PAY_LAST = PCNT_W'(PAYLOAD_FLITS - 1);

    typedef enum logic [1:0] {
        LOAD_ADDR,
        REQUEST,
        SEND_HDR,
        SEND_PAYLOAD
    } state_t;

    typedef struct packed {
        logic [4:0]        req;
        logic [2:0]        dport;
        logic [ADDR_W-1:0] next;
    } route_t;

    // XY routing on the two's-complement halves; the offset moved along is stepped
    // one hop towards zero with h-bit wraparound.
    function automatic route_t xy_route(input logic [ADDR_W-1:0] addr);
        logic signed [HALF-1:0] dx;
        logic signed [HALF-1:0] dy;
        logic signed [HALF-1:0] zero;
        logic signed [HALF-1:0] one;
        route_t r;
        r    = '0;
        zero = '0;
        one  = HALF'(1);
        dx   = addr[HALF-1:0];
        dy   = addr[ADDR_W-1:HALF];
        if (dx > zero) begin
            r.req   = 5'b00010;
            r.dport = 3'd1;
            dx      = dx - one;
        end else if (dx < zero) begin
            r.req   = 5'b00001;
            r.dport = 3'd0;
            dx      = dx + one;
        end else if (dy > zero) begin
            r.req   = 5'b01000;
            r.dport = 3'd3;
            dy      = dy - one;
        end else if (dy < zero) begin
            r.req   = 5'b00100;
            r.dport = 3'd2;
            dy      = dy + one;
        end else begin
            r.req   = 5'b10000;
            r.dport = 3'd4;
        end
        r.next = {dy, dx};
        return r;
    endfunction

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   next_addr;
    logic [HCNT_W-1:0]   hdr_cnt;
    logic [PCNT_W-1:0]   pay_cnt;
    logic [4:0]          request_q;
    logic [2:0]          dport_q;
    logic                done_q;

    logic [ADDR_W-1:0]   addr_in;
    route_t              rt;
    logic                dest_full;
    logic                go;
    logic                read_c;
    logic                valid_c;
    logic [FLIT_W-1:0]   flit_c;

    // Header arrives LSB flit first, so each new flit enters at the top.
    assign addr_in   = (addr >> FLIT_W) | (ADDR_W'(port.fifo_flit) << (ADDR_W - FLIT_W));
    assign rt        = xy_route(addr_in);
    assign dest_full = |(request_q & port.dest_full_vector);
    assign go        = port.grant && !dest_full;

    // FIFO pops and flit transfers must react in the same cycle as the handshake inputs.
    always_comb begin
        read_c  = 1'b0;
        valid_c = 1'b0;
        flit_c  = '0;
        if (reset) begin
            case (state)
                LOAD_ADDR: read_c = !port.fifo_empty;
                SEND_HDR: begin
                    if (go) begin
                        valid_c = 1'b1;
                        flit_c  = next_addr[FLIT_W-1:0];
                    end
                end
                SEND_PAYLOAD: begin
                    if (go && !port.fifo_empty) begin
                        read_c  = 1'b1;
                        valid_c = 1'b1;
                        flit_c  = port.fifo_flit;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= LOAD_ADDR;
            addr      <= '0;
            next_addr <= '0;
            hdr_cnt   <= '0;
            pay_cnt   <= '0;
            request_q <= '0;
            dport_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                LOAD_ADDR: begin
                    if (!port.fifo_empty) begin
                        addr <= addr_in;
                        if (hdr_cnt == HDR_LAST) begin
                            hdr_cnt   <= '0;
                            request_q <= rt.req;
                            dport_q   <= rt.dport;
                            next_addr <= rt.next;
                            state     <= REQUEST;
                        end else begin
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end
                    end
                end
                REQUEST: begin
                    if (go) state <= SEND_HDR;
                end
                SEND_HDR: begin
                    if (go) begin
                        next_addr <= next_addr >> FLIT_W;
                        if (hdr_cnt == HDR_LAST) begin
                            hdr_cnt <= '0;
                            state   <= SEND_PAYLOAD;
                        end else begin
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end
                    end
                end
                SEND_PAYLOAD: begin
                    if (go && !port.fifo_empty) begin
                        if (pay_cnt == PAY_LAST) begin
                            pay_cnt   <= '0;
                            request_q <= '0;
                            dport_q   <= '0;
                            done_q    <= 1'b1;
                            state     <= LOAD_ADDR;
                        end else begin
                            pay_cnt <= pay_cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD_ADDR;
            endcase
        end
    end

    assign port.read_fifo        = read_c;
    assign port.flit_valid       = valid_c;
    assign port.flit_out         = flit_c;
    assign port.request_vector   = request_q;
    assign port.destination_port = dport_q;
    assign port.packet_done      = done_q;
    assign port.busy             = (state != LOAD_ADDR) || (hdr_cnt != '0);
endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port: a queue-based FIFO, a transaction-level port model
// compared every cycle, and literal per-cycle expectations for each scenario.
module tb_router_input_port;
    localparam int FLIT_W        = 4;
    localparam int ADDR_W        = 16;
    localparam int PAYLOAD_FLITS = 4;
    localparam int H             = ADDR_W / FLIT_W;
    localparam int HALF          = ADDR_W / 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    router_input_port_if #(.FLIT_W(FLIT_W)) bus ();

    router_input_port #(
        .FLIT_W(FLIT_W),
        .ADDR_W(ADDR_W),
        .PAYLOAD_FLITS(PAYLOAD_FLITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .port(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    logic [3:0] fifo_q[$];
    logic       hold    = 1'b0;
    logic       rd_seen = 1'b0;
    logic [3:0] exp8[8];

    // Transaction-level model of one packet in flight.
    int         m_hdr[$];
    bit         m_routed  = 1'b0;
    bit         m_granted = 1'b0;
    int         m_hsent   = 0;
    int         m_psent   = 0;
    logic [4:0] m_req     = 5'd0;
    logic [2:0] m_port    = 3'd0;
    int         m_next[H];
    bit         m_done    = 1'b0;

    logic [4:0] req_log[0:1023];
    logic [2:0] port_log[0:1023];
    logic       vld_log[0:1023];
    logic       rd_log[0:1023];
    logic       busy_log[0:1023];
    logic       done_log[0:1023];
    logic [3:0] flit_log[0:1023];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_route();
        int addr, dx, dy, nxt;
        addr = 0;
        for (int i = 0; i < H; i++) addr += m_hdr[i] << (FLIT_W * i);
        dx = addr & ((1 << HALF) - 1);
        dy = (addr >> HALF) & ((1 << HALF) - 1);
        if (dx >= (1 << (HALF - 1))) dx -= (1 << HALF);
        if (dy >= (1 << (HALF - 1))) dy -= (1 << HALF);
        if (dx > 0) begin
            m_req = 5'b00010; m_port = 3'd1; dx--;
        end else if (dx < 0) begin
            m_req = 5'b00001; m_port = 3'd0; dx++;
        end else if (dy > 0) begin
            m_req = 5'b01000; m_port = 3'd3; dy--;
        end else if (dy < 0) begin
            m_req = 5'b00100; m_port = 3'd2; dy++;
        end else begin
            m_req = 5'b10000; m_port = 3'd4;
        end
        nxt = ((dy & ((1 << HALF) - 1)) << HALF) | (dx & ((1 << HALF) - 1));
        for (int i = 0; i < H; i++) m_next[i] = (nxt >> (FLIT_W * i)) & ((1 << FLIT_W) - 1);
    endtask

    task automatic model_clear();
        m_hdr.delete();
        m_routed  = 1'b0;
        m_granted = 1'b0;
        m_hsent   = 0;
        m_psent   = 0;
        m_req     = 5'd0;
        m_port    = 3'd0;
    endtask

    always @(negedge clk) begin : compare
        logic       go;
        logic       e_rd;
        logic       e_vld;
        logic [3:0] e_flit;
        cyc++;
        go     = bus.grant && ((m_req & bus.dest_full_vector) == 5'd0);
        e_rd   = 1'b0;
        e_vld  = 1'b0;
        e_flit = 4'h0;
        if (reset) begin
            if (!m_routed) begin
                e_rd = !bus.fifo_empty;
            end else if (m_granted && m_hsent < H) begin
                if (go) begin
                    e_vld  = 1'b1;
                    e_flit = 4'(m_next[m_hsent]);
                end
            end else if (m_granted && go && !bus.fifo_empty) begin
                e_rd   = 1'b1;
                e_vld  = 1'b1;
                e_flit = bus.fifo_flit;
            end
        end
        check("read_fifo", 32'(bus.read_fifo), 32'(e_rd));
        check("flit_valid", 32'(bus.flit_valid), 32'(e_vld));
        check("flit_out", 32'(bus.flit_out), 32'(e_flit));
        check("request_vector", 32'(bus.request_vector), 32'(m_req));
        check("destination_port", 32'(bus.destination_port), 32'(m_port));
        check("packet_done", 32'(bus.packet_done), 32'(m_done));
        check("busy", 32'(bus.busy), 32'(m_routed || (m_hdr.size() > 0)));

        req_log[cyc]  = bus.request_vector;
        port_log[cyc] = bus.destination_port;
        vld_log[cyc]  = bus.flit_valid;
        rd_log[cyc]   = bus.read_fifo;
        busy_log[cyc] = bus.busy;
        done_log[cyc] = bus.packet_done;
        flit_log[cyc] = bus.flit_out;
        rd_seen       = bus.read_fifo;

        m_done = 1'b0;
        if (!reset) begin
            model_clear();
        end else if (!m_routed) begin
            if (!bus.fifo_empty) begin
                m_hdr.push_back(int'(bus.fifo_flit));
                if (m_hdr.size() == H) begin
                    model_route();
                    m_routed = 1'b1;
                end
            end
        end else if (!m_granted) begin
            if (go) m_granted = 1'b1;
        end else if (m_hsent < H) begin
            if (go) m_hsent++;
        end else if (go && !bus.fifo_empty) begin
            m_psent++;
            if (m_psent == PAYLOAD_FLITS) begin
                m_done = 1'b1;
                model_clear();
            end
        end
    end

    task automatic drive_fifo();
        bus.fifo_empty = hold || (fifo_q.size() == 0);
        bus.fifo_flit  = bus.fifo_empty ? 4'h0 : fifo_q[0];
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
            drive_fifo();
        end
    endtask

    task automatic check_flits(input string name, input int first);
        for (int i = 0; i < 8; i++) begin
            check(name, {27'd0, vld_log[first + i], flit_log[first + i]}, {27'd0, 1'b1, exp8[i]});
        end
    endtask

    initial begin
        bus.grant            = 1'b1;
        bus.dest_full_vector = 5'd0;
        drive_fifo();
        tick(2);
        check("reset_req", 32'(bus.request_vector), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_valid", 32'(bus.flit_valid), 32'd0);
        reset = 1'b1;

        // East by 2: header 2,0,0,0 becomes 1,0,0,0.
        fifo_q = '{4'h2, 4'h0, 4'h0, 4'h0, 4'hA, 4'hB, 4'hC, 4'hD};
        drive_fifo();
        base = cyc;
        tick(16);
        check("s1_req_c5", 32'(req_log[base + 5]), 32'b00010);
        check("s1_port_c5", 32'(port_log[base + 5]), 32'd1);
        check("s1_novalid_c5", 32'(vld_log[base + 5]), 32'd0);
        exp8 = '{4'h1, 4'h0, 4'h0, 4'h0, 4'hA, 4'hB, 4'hC, 4'hD};
        check_flits("s1_flits", base + 6);
        check("s1_done_c13", 32'(done_log[base + 13]), 32'd0);
        check("s1_done_c14", 32'(done_log[base + 14]), 32'd1);
        check("s1_req_clear_c14", 32'(req_log[base + 14]), 32'd0);
        check("s1_drained", 32'(fifo_q.size()), 32'd0);

        // dy = -1: south, header returns to zero.
        fifo_q = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4};
        drive_fifo();
        base = cyc;
        tick(15);
        check("s2_req", 32'(req_log[base + 5]), 32'b00100);
        check("s2_port", 32'(port_log[base + 5]), 32'd2);
        exp8 = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
        check_flits("s2_flits", base + 6);
        check("s2_done", 32'(done_log[base + 14]), 32'd1);

        // Local, with every other output reporting full: no stall expected.
        bus.dest_full_vector = 5'b01111;
        fifo_q = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h6, 4'h7, 4'h8};
        drive_fifo();
        base = cyc;
        tick(15);
        bus.dest_full_vector = 5'd0;
        check("s3_req", 32'(req_log[base + 5]), 32'b10000);
        check("s3_port", 32'(port_log[base + 5]), 32'd4);
        exp8 = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h6, 4'h7, 4'h8};
        check_flits("s3_flits", base + 6);
        check("s3_done", 32'(done_log[base + 14]), 32'd1);

        // Grant withheld 3 cycles in REQUEST, then east output full for 2 payload cycles.
        bus.grant = 1'b0;
        fifo_q = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h9, 4'hA, 4'hB, 4'hC};
        drive_fifo();
        base = cyc;
        tick(7);
        bus.grant = 1'b1;
        tick(7);
        bus.dest_full_vector = 5'b00010;
        tick(2);
        bus.dest_full_vector = 5'd0;
        tick(4);
        for (int c = 5; c <= 8; c++) check("s4_wait_grant", 32'(vld_log[base + c]), 32'd0);
        for (int c = 9; c <= 14; c++) check("s4_flowing", 32'(vld_log[base + c]), 32'd1);
        for (int c = 15; c <= 16; c++) begin
            check("s4_full_novalid", 32'(vld_log[base + c]), 32'd0);
            check("s4_full_noread", 32'(rd_log[base + c]), 32'd0);
        end
        check("s4_hdr0", 32'(flit_log[base + 9]), 32'h2);
        check("s4_pay0", 32'(flit_log[base + 13]), 32'h9);
        check("s4_pay1", 32'(flit_log[base + 14]), 32'hA);
        check("s4_pay2", 32'(flit_log[base + 17]), 32'hB);
        check("s4_pay3", 32'(flit_log[base + 18]), 32'hC);
        check("s4_done", 32'(done_log[base + 19]), 32'd1);

        // FIFO runs dry for 4 cycles between header flits 2 and 3; dx = -2 routes west.
        fifo_q = '{4'hE, 4'hF, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
        drive_fifo();
        base = cyc;
        tick(2);
        hold = 1'b1;
        drive_fifo();
        tick(4);
        hold = 1'b0;
        drive_fifo();
        tick(14);
        for (int c = 3; c <= 6; c++) begin
            check("s5_gap_noread", 32'(rd_log[base + c]), 32'd0);
            check("s5_gap_busy", 32'(busy_log[base + c]), 32'd1);
        end
        check("s5_req", 32'(req_log[base + 9]), 32'b00001);
        check("s5_port", 32'(port_log[base + 9]), 32'd0);
        check("s5_hdr0", 32'(flit_log[base + 10]), 32'hF);
        check("s5_hdr1", 32'(flit_log[base + 11]), 32'hF);
        check("s5_done", 32'(done_log[base + 18]), 32'd1);
        check("s5_drained", 32'(fifo_q.size()), 32'd0);

        // Reset after two payload flits; the unread 3,4,0,0 become the next header (dx = 0x43).
        fifo_q = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0,
                   4'h7, 4'h8, 4'h9, 4'hA};
        drive_fifo();
        base = cyc;
        tick(11);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(16);
        check("s6_pay1", 32'(flit_log[base + 11]), 32'h2);
        check("s6_rst_noread", 32'(rd_log[base + 12]), 32'd0);
        check("s6_after_req", 32'(req_log[base + 13]), 32'd0);
        check("s6_after_port", 32'(port_log[base + 13]), 32'd0);
        check("s6_after_valid", 32'(vld_log[base + 13]), 32'd0);
        check("s6_after_read", 32'(rd_log[base + 13]), 32'd0);
        check("s6_after_busy", 32'(busy_log[base + 13]), 32'd0);
        check("s6_after_done", 32'(done_log[base + 13]), 32'd0);
        check("s6_new_req", 32'(req_log[base + 18]), 32'b00010);
        check("s6_new_hdr0", 32'(flit_log[base + 19]), 32'h2);
        check("s6_new_hdr1", 32'(flit_log[base + 20]), 32'h4);
        check("s6_new_pay0", 32'(flit_log[base + 23]), 32'h7);
        check("s6_new_done", 32'(done_log[base + 27]), 32'd1);
        check("s6_drained", 32'(fifo_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
